// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle control FSM for the LEGv8 datapath: sequences fetch/decode/execute/memory/write-back.
// Optional feature macro: LEGV8_CTRL_PERF_EN adds cycle_cnt/retired_cnt performance counters.
module legv8_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 256
`ifdef LEGV8_CTRL_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        reg_to_loc,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        instr_done,
    output logic        trap,
    output logic        trap_cause
`ifdef LEGV8_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] retired_cnt
`endif
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_WB_R     = 4'd4;
    localparam logic [3:0] S_ADDR     = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_WB_MEM   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_EXEC_CBZ = 4'd9;
    localparam logic [3:0] S_EXEC_B   = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam int         CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]       state_reg, state_next;
    logic             cause_reg, cause_next;
    logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             mem_wait;
    logic             tmo_hit;

    // Counter only runs while an access is stalled, so every mem state is entered with it at zero.
    assign mem_wait     = mem_req & ~mem_ready;
    assign tmo_hit      = mem_wait && (tmo_cnt_reg == TMO_LAST);
    assign tmo_cnt_next = mem_wait ? tmo_cnt_reg + 1'b1 : '0;

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (tmo_hit) begin
                    state_next = S_TRAP;
                    cause_next = 1'b1;
                end
            end
            S_DECODE: begin
                casez (opcode)
                    11'b10001011000,
                    11'b11001011000,
                    11'b10001010000,
                    11'b10101010000: state_next = S_EXEC_R;
                    11'b11111000010,
                    11'b11111000000: state_next = S_ADDR;
                    11'b10110100???: state_next = S_EXEC_CBZ;
                    11'b000101?????: state_next = S_EXEC_B;
                    default: begin
                        state_next = S_TRAP;
                        cause_next = 1'b0;
                    end
                endcase
            end
            S_EXEC_R: state_next = S_WB_R;
            S_WB_R:   state_next = S_FETCH;
            // Only LDUR and STUR reach here; opcode bit 1 separates them.
            S_ADDR:   state_next = opcode[1] ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_next = S_WB_MEM;
                end else if (tmo_hit) begin
                    state_next = S_TRAP;
                    cause_next = 1'b1;
                end
            end
            S_WB_MEM: state_next = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (tmo_hit) begin
                    state_next = S_TRAP;
                    cause_next = 1'b1;
                end
            end
            S_EXEC_CBZ: state_next = S_FETCH;
            S_EXEC_B:   state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cause_reg   <= 1'b0;
            tmo_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cause_reg   <= cause_next;
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end

    // Moore decode; the mem_ready-qualified strobes are masked by reset so a completing access is not reported.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_to_loc = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready & ~reset;
                pc_write = mem_ready & ~reset;
            end
            S_EXEC_R: alu_op = 2'b10;
            S_WB_R: begin
                alu_op     = 2'b10;
                reg_write  = 1'b1;
                instr_done = ~reset;
            end
            S_ADDR: begin
                alu_src    = 1'b1;
                reg_to_loc = 1'b1;
            end
            S_MEM_RD: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                alu_src    = 1'b1;
                reg_to_loc = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = ~reset;
            end
            S_MEM_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                iord       = 1'b1;
                alu_src    = 1'b1;
                reg_to_loc = 1'b1;
                instr_done = mem_ready & ~reset;
            end
            S_EXEC_CBZ: begin
                alu_op     = 2'b01;
                reg_to_loc = 1'b1;
                pc_write   = zero & ~reset;
                pc_src     = zero;
                instr_done = ~reset;
            end
            S_EXEC_B: begin
                pc_write   = ~reset;
                pc_src     = 1'b1;
                instr_done = ~reset;
            end
            default: ;
        endcase
    end

    assign trap       = (state_reg == S_TRAP);
    assign trap_cause = cause_reg;

`ifdef LEGV8_CTRL_PERF_EN
    logic [PERF_W-1:0] cycle_cnt_reg;
    logic [PERF_W-1:0] retired_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_reg   <= '0;
            retired_cnt_reg <= '0;
        end else begin
            if (state_reg != S_TRAP) begin
                cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
            end
            if (instr_done) begin
                retired_cnt_reg <= retired_cnt_reg + 1'b1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_reg;
    assign retired_cnt = retired_cnt_reg;
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard bench for legv8_multicycle_ctrl: stimulus pushes per-cycle expected controls, a monitor compares.
module tb_legv8_multicycle_ctrl;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010100110;
    localparam logic [10:0] OP_ILL  = 11'b11111111111;

    // Observed vector bit positions
    localparam logic [14:0] B_MREQ  = 15'h4000;
    localparam logic [14:0] B_MWE   = 15'h2000;
    localparam logic [14:0] B_IORD  = 15'h1000;
    localparam logic [14:0] B_IRW   = 15'h0800;
    localparam logic [14:0] B_PCW   = 15'h0400;
    localparam logic [14:0] B_PCSRC = 15'h0200;
    localparam logic [14:0] B_RW    = 15'h0100;
    localparam logic [14:0] B_M2R   = 15'h0080;
    localparam logic [14:0] B_R2L   = 15'h0040;
    localparam logic [14:0] B_ASRC  = 15'h0020;
    localparam logic [14:0] B_AOP_R = 15'h0010;
    localparam logic [14:0] B_AOP_P = 15'h0008;
    localparam logic [14:0] B_DONE  = 15'h0004;
    localparam logic [14:0] B_TRAP  = 15'h0002;
    localparam logic [14:0] B_CAUSE = 15'h0001;
    localparam logic [14:0] M_ALL   = 15'h7FFF;

    localparam logic [14:0] E_ZERO       = 15'h0000;
    localparam logic [14:0] E_FETCH_WAIT = B_MREQ;
    localparam logic [14:0] E_FETCH_RDY  = B_MREQ | B_IRW | B_PCW;
    localparam logic [14:0] E_EXEC_R     = B_AOP_R;
    localparam logic [14:0] E_WB_R       = B_AOP_R | B_RW | B_DONE;
    localparam logic [14:0] E_ADDR       = B_ASRC | B_R2L;
    localparam logic [14:0] E_MEM_RD     = B_MREQ | B_IORD | B_ASRC | B_R2L;
    localparam logic [14:0] E_WB_MEM     = B_RW | B_M2R | B_DONE;
    localparam logic [14:0] E_MEM_WR     = B_MREQ | B_MWE | B_IORD | B_ASRC | B_R2L;
    localparam logic [14:0] E_CBZ_T      = B_AOP_P | B_R2L | B_PCW | B_PCSRC | B_DONE;
    localparam logic [14:0] E_CBZ_F      = B_AOP_P | B_R2L | B_DONE;
    localparam logic [14:0] E_B          = B_PCW | B_PCSRC | B_DONE;
    localparam logic [14:0] E_TRAP0      = B_TRAP;
    localparam logic [14:0] E_TRAP1      = B_TRAP | B_CAUSE;

    typedef struct {
        string       name;
        logic [14:0] exp;
        logic [14:0] mask;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] opcode = OP_ADD;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src;
    logic        reg_write, mem_to_reg, reg_to_loc, alu_src;
    logic [1:0]  alu_op;
    logic        instr_done, trap, trap_cause;
`ifdef LEGV8_CTRL_PERF_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    logic [14:0] obs;
    logic [10:0] op_v = OP_ADD;
    logic        z_v = 1'b0;
    sb_t         sb[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    legv8_multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .reg_to_loc (reg_to_loc),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .trap       (trap),
        .trap_cause (trap_cause)
`ifdef LEGV8_CTRL_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .retired_cnt(retired_cnt)
`endif
    );

    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
                  mem_to_reg, reg_to_loc, alu_src, alu_op, instr_done, trap, trap_cause};

    // One cycle of stimulus: inputs change shortly after the rising edge, expectation queued for this cycle.
    task automatic step(input string nm, input logic r, input logic rd, input logic zz,
                        input logic [10:0] o, input logic [14:0] e, input logic [14:0] m);
        @(posedge clk);
        #2;
        reset     = r;
        mem_ready = rd;
        zero      = zz;
        opcode    = o;
        if (m != 15'h0) sb.push_back('{name: nm, exp: e, mask: m});
    endtask

    task automatic cyc(input string nm, input logic rd, input logic [14:0] e);
        step(nm, 1'b0, rd, z_v, op_v, e, M_ALL);
    endtask

`ifdef LEGV8_CTRL_PERF_EN
    task automatic chk_perf(input string nm, input logic [31:0] exp_cyc, input logic [31:0] exp_ret);
        checks++;
        if (cycle_cnt !== exp_cyc || retired_cnt !== exp_ret) begin
            errors++;
            $display("FAIL %s: cycle_cnt=%0d retired_cnt=%0d, wanted %0d/%0d",
                     nm, cycle_cnt, retired_cnt, exp_cyc, exp_ret);
        end else begin
            $display("ok   %s: cycle_cnt=%0d retired_cnt=%0d", nm, cycle_cnt, retired_cnt);
        end
    endtask
`endif

    // Monitor: compares the DUT outputs against the queued expectation mid-cycle.
    initial begin
        sb_t t;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                t = sb.pop_front();
                checks++;
                if ((obs & t.mask) !== (t.exp & t.mask)) begin
                    errors++;
                    $display("FAIL %s: got %h, wanted %h (mask %h)", t.name, obs, t.exp, t.mask);
                end else begin
                    $display("ok   %s: %h", t.name, obs);
                end
            end
        end
    end

    initial begin
        step("rst_settle", 1'b1, 1'b0, 1'b0, OP_ADD, E_ZERO, 15'h0);
        step("reset", 1'b1, 1'b1, 1'b0, OP_ADD, E_ZERO, M_ALL);

        // ADD with memory always ready
        op_v = OP_ADD;
        cyc("add_idle", 1'b1, E_ZERO);
        cyc("add_fetch", 1'b1, E_FETCH_RDY);
        cyc("add_decode", 1'b1, E_ZERO);
        cyc("add_exec", 1'b1, E_EXEC_R);
        cyc("add_wb", 1'b1, E_WB_R);

        // LDUR with three wait cycles in MEM_RD
        op_v = OP_LDUR;
        cyc("ldur_fetch", 1'b1, E_FETCH_RDY);
        cyc("ldur_decode", 1'b0, E_ZERO);
        cyc("ldur_addr", 1'b0, E_ADDR);
        for (int i = 0; i < 3; i++) cyc("ldur_mem_wait", 1'b0, E_MEM_RD);
        cyc("ldur_mem_done", 1'b1, E_MEM_RD);
        cyc("ldur_wb", 1'b0, E_WB_MEM);

        op_v = OP_ORR;
        cyc("orr_fetch", 1'b1, E_FETCH_RDY);
        cyc("orr_decode", 1'b0, E_ZERO);
        cyc("orr_exec", 1'b0, E_EXEC_R);
        cyc("orr_wb", 1'b0, E_WB_R);

        op_v = OP_STUR;
        cyc("stur_fetch", 1'b1, E_FETCH_RDY);
        cyc("stur_decode", 1'b0, E_ZERO);
        cyc("stur_addr", 1'b0, E_ADDR);
        cyc("stur_mem_wait", 1'b0, E_MEM_WR);
        cyc("stur_mem_done", 1'b1, E_MEM_WR | B_DONE);

        op_v = OP_CBZ;
        z_v  = 1'b1;
        cyc("cbz_t_fetch", 1'b1, E_FETCH_RDY);
        cyc("cbz_t_decode", 1'b0, E_ZERO);
        cyc("cbz_taken", 1'b0, E_CBZ_T);
        z_v  = 1'b0;
        cyc("cbz_f_fetch", 1'b1, E_FETCH_RDY);
        cyc("cbz_f_decode", 1'b0, E_ZERO);
        cyc("cbz_not_taken", 1'b0, E_CBZ_F);

        op_v = OP_B;
        cyc("b_fetch", 1'b1, E_FETCH_RDY);
        cyc("b_decode", 1'b0, E_ZERO);
        cyc("b_exec", 1'b0, E_B);

        // Fetch timeout after four stalled cycles
        for (int i = 0; i < 4; i++) cyc("tmo_fetch_wait", 1'b0, E_FETCH_WAIT);
        for (int i = 0; i < 3; i++) cyc("tmo_trap", 1'b1, E_TRAP1);
        step("tmo_reset", 1'b1, 1'b0, 1'b0, op_v, E_TRAP1, M_ALL);
        cyc("tmo_idle", 1'b1, E_ZERO);

        // Ready on the limit cycle completes the access
        for (int i = 0; i < 3; i++) cyc("lim_fetch_wait", 1'b0, E_FETCH_WAIT);
        cyc("lim_fetch_rdy", 1'b1, E_FETCH_RDY);
        cyc("lim_decode", 1'b0, E_ZERO);
        cyc("lim_b_exec", 1'b0, E_B);

        // Illegal opcode
        op_v = OP_ILL;
        cyc("ill_fetch", 1'b1, E_FETCH_RDY);
        cyc("ill_decode", 1'b1, E_ZERO);
        for (int i = 0; i < 20; i++) cyc("ill_trap", 1'b1, E_TRAP0);
        step("ill_reset", 1'b1, 1'b0, 1'b0, op_v, E_TRAP0, M_ALL);
        cyc("ill_idle", 1'b0, E_ZERO);

        // Reset during a completing STUR write
        op_v = OP_STUR;
        cyc("rw_fetch", 1'b1, E_FETCH_RDY);
        cyc("rw_decode", 1'b0, E_ZERO);
        cyc("rw_addr", 1'b0, E_ADDR);
        step("rw_reset_in_memwr", 1'b1, 1'b1, 1'b0, op_v, E_MEM_WR, M_ALL);
        cyc("rw_idle", 1'b1, E_ZERO);
`ifdef LEGV8_CTRL_PERF_EN
        #1 chk_perf("perf_after_reset", 32'd0, 32'd0);
`endif
        op_v = OP_B;
        for (int i = 0; i < 3; i++) begin
            cyc("pb_fetch", 1'b1, E_FETCH_RDY);
            cyc("pb_decode", 1'b0, E_ZERO);
            cyc("pb_exec", 1'b0, E_B);
        end
        cyc("pb_fetch_next", 1'b0, E_FETCH_WAIT);
`ifdef LEGV8_CTRL_PERF_EN
        #1 chk_perf("perf_three_b", 32'd10, 32'd3);
`endif

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, wanted 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
